// File: rtl/nrz_symbol_mapper.sv
// Bit-to-NRZ symbol mapper: buffers a serial bit stream and emits each bit as a
// signed +/-AMPL level held for OSR enabled samples, feeding the gaussian FIR.
module nrz_symbol_mapper #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned OSR        = 8,
    parameter logic [31:0] AMPL       = 32'h00000100,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         nreset,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    output logic                         bit_ready,
    input  logic                         enable,
    output logic [WIDTH-1:0]             xn,
    output logic                         xn_valid,
    output logic                         underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [WIDTH-1:0] LVL_POS  = WIDTH'(AMPL);
    localparam logic [WIDTH-1:0] LVL_NEG  = ~LVL_POS + WIDTH'(1);
    localparam logic [PW-1:0]    PH_FIRST = (OSR > 1) ? PW'(1) : '0;
    localparam logic [PW-1:0]    PH_LAST  = PW'(OSR - 1);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t                state;
    logic [PW-1:0]         phase;
    logic [FIFO_DEPTH-1:0] mem;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  head;
    logic [WIDTH-1:0]      head_level;

    // Ready ignores a same-cycle pop, so a full FIFO stalls the writer for one edge.
    assign bit_ready  = (fifo_level < LW'(FIFO_DEPTH));
    assign push       = bit_valid && bit_ready;
    assign pop        = enable && (phase == '0) && (fifo_level != '0);
    assign head       = mem[rd_ptr];
    assign head_level = head ? LVL_POS : LVL_NEG;

    // Bit storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= bit_in;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Symbol sequencer: phase 0 is the symbol boundary where the next bit is taken.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state    <= S_IDLE;
            phase    <= '0;
            xn       <= '0;
            xn_valid <= 1'b0;
            underrun <= 1'b0;
        end else begin
            xn_valid <= enable;
            underrun <= 1'b0;
            if (enable) begin
                case (state)
                    S_IDLE: begin
                        if (pop) begin
                            xn    <= head_level;
                            phase <= PH_FIRST;
                            state <= S_ACTIVE;
                        end else begin
                            xn <= '0;
                        end
                    end
                    S_ACTIVE: begin
                        if (phase != '0) begin
                            phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
                        end else if (pop) begin
                            xn    <= head_level;
                            phase <= PH_FIRST;
                        end else begin
                            xn       <= '0;
                            underrun <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        phase <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nrz_symbol_mapper.sv
// Self-checking bench for nrz_symbol_mapper: expected samples are queued as bits are
// accepted and compared against xn/underrun on every valid output sample.
module tb_nrz_symbol_mapper;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned OSR   = 8;
    localparam logic [31:0] POS   = 32'h00000100;
    localparam logic [31:0] NEG   = 32'hFFFFFF00;

    logic             clock;
    logic             nreset;
    logic             bit_in, bit_valid, bit_ready, enable;
    logic [WIDTH-1:0] xn;
    logic             xn_valid, underrun;
    logic [2:0]       fifo_level;
    logic             bit_in1, bit_valid1, bit_ready1, enable1;
    logic [WIDTH-1:0] xn1;
    logic             xn_valid1, underrun1;
    logic [2:0]       fifo_level1;

    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];

    nrz_symbol_mapper #(.WIDTH(WIDTH), .OSR(OSR), .AMPL(POS), .FIFO_DEPTH(4)) u_dut (
        .clock(clock), .nreset(nreset), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .enable(enable), .xn(xn), .xn_valid(xn_valid),
        .underrun(underrun), .fifo_level(fifo_level)
    );

    nrz_symbol_mapper #(.WIDTH(WIDTH), .OSR(1), .AMPL(POS), .FIFO_DEPTH(4)) u_dut1 (
        .clock(clock), .nreset(nreset), .bit_in(bit_in1), .bit_valid(bit_valid1),
        .bit_ready(bit_ready1), .enable(enable1), .xn(xn1), .xn_valid(xn_valid1),
        .underrun(underrun1), .fifo_level(fifo_level1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        nreset = 1'b0;
        bit_in = 1'b0; bit_valid = 1'b0; enable = 1'b0;
        bit_in1 = 1'b0; bit_valid1 = 1'b0; enable1 = 1'b0;
        #12;
        checks++;
        if ({xn, xn_valid, underrun, fifo_level, bit_ready} !== {32'h0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got xn=%h v=%b u=%b lvl=%0d rdy=%b want 0/0/0/0/1",
                     xn, xn_valid, underrun, fifo_level, bit_ready);
        end
        checks++;
        if ({xn1, xn_valid1, underrun1, fifo_level1, bit_ready1} !== {32'h0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state_osr1: got xn=%h v=%b u=%b lvl=%0d rdy=%b want 0/0/0/0/1",
                     xn1, xn_valid1, underrun1, fifo_level1, bit_ready1);
        end
        @(negedge clock);
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_stream;
        bit tx[$] = '{1'b1, 1'b0, 1'b1};
        bit b, sent;
        logic [32:0] e;
        int cyc = 0;
        enable = 1'b1;
        exp_q.push_back({1'b0, 32'h0});
        while (exp_q.size() > 0 && cyc < 100) begin
            sent = 1'b0;
            if (tx.size() > 0) begin
                bit_valid = 1'b1; bit_in = tx[0]; sent = bit_ready;
            end else begin
                bit_valid = 1'b0;
            end
            tick();
            if (sent) begin
                b = tx.pop_front();
                repeat (OSR) exp_q.push_back({1'b0, b ? POS : NEG});
                if (tx.size() == 0) exp_q.push_back({1'b1, 32'h0});
            end
            if (xn_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({underrun, xn} !== e) begin
                    errors++;
                    $display("FAIL stream cyc=%0d: got u=%b xn=%h want u=%b xn=%h",
                             cyc, underrun, xn, e[32], e[31:0]);
                end
            end
            cyc++;
        end
        bit_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_timeout: got %0d samples left want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) begin
            tick();
            checks++;
            if ({underrun, xn, fifo_level} !== {1'b0, 32'h0, 3'd0}) begin
                errors++;
                $display("FAIL stream_idle: got u=%b xn=%h lvl=%0d want 0/0/0", underrun, xn, fifo_level);
            end
        end
    endtask

    task automatic test_fill;
        bit tx[$] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            bit_in = tx[i];
            checks++;
            if (bit_ready !== (i < 4)) begin
                errors++;
                $display("FAIL fill_ready i=%0d: got %b want %b", i, bit_ready, (i < 4));
            end
            tick();
            if (i < 4) repeat (OSR) exp_q.push_back({1'b0, tx[i] ? POS : NEG});
            checks++;
            if ({xn_valid, xn, fifo_level} !== {1'b0, 32'h0, 3'((i < 4) ? i + 1 : 4)}) begin
                errors++;
                $display("FAIL fill i=%0d: got v=%b xn=%h lvl=%0d want 0/0/%0d",
                         i, xn_valid, xn, fifo_level, (i < 4) ? i + 1 : 4);
            end
        end
    endtask

    task automatic test_back_to_back;
        bit tx[$] = '{1'b0, 1'b1, 1'b0};
        bit b, sent;
        logic [32:0] e;
        int cyc = 0;
        enable = 1'b1;
        while (exp_q.size() > 0 && cyc < 200) begin
            sent = 1'b0;
            if (tx.size() > 0) begin
                bit_valid = 1'b1; bit_in = tx[0]; sent = bit_ready;
            end else begin
                bit_valid = 1'b0;
            end
            tick();
            if (sent) begin
                b = tx.pop_front();
                repeat (OSR) exp_q.push_back({1'b0, b ? POS : NEG});
                if (tx.size() == 0) exp_q.push_back({1'b1, 32'h0});
            end
            if (cyc < 2) begin
                checks++;
                if (fifo_level !== 3'(3 + cyc)) begin
                    errors++;
                    $display("FAIL b2b_level cyc=%0d: got %0d want %0d", cyc, fifo_level, 3 + cyc);
                end
            end
            if (xn_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({underrun, xn} !== e) begin
                    errors++;
                    $display("FAIL b2b cyc=%0d: got u=%b xn=%h want u=%b xn=%h",
                             cyc, underrun, xn, e[32], e[31:0]);
                end
            end
            cyc++;
        end
        bit_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d samples left want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_enable_toggle;
        bit tx[2] = '{1'b1, 1'b0};
        logic [32:0] e;
        logic [31:0] prev_xn;
        logic en;
        int cyc = 0;
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_valid = 1'b1; bit_in = tx[i];
            tick();
            repeat (OSR) exp_q.push_back({1'b0, tx[i] ? POS : NEG});
        end
        exp_q.push_back({1'b1, 32'h0});
        bit_valid = 1'b0;
        while (exp_q.size() > 0 && cyc < 100) begin
            en = (cyc % 2 == 0);
            enable = en;
            prev_xn = xn;
            tick();
            checks++;
            if (xn_valid !== en) begin
                errors++;
                $display("FAIL toggle_valid cyc=%0d: got %b want %b", cyc, xn_valid, en);
            end
            if (xn_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({underrun, xn} !== e) begin
                    errors++;
                    $display("FAIL toggle cyc=%0d: got u=%b xn=%h want u=%b xn=%h",
                             cyc, underrun, xn, e[32], e[31:0]);
                end
            end else begin
                checks++;
                if (xn !== prev_xn) begin
                    errors++;
                    $display("FAIL toggle_hold cyc=%0d: got %h want %h", cyc, xn, prev_xn);
                end
            end
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL toggle_timeout: got %0d samples left want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_midstream;
        bit tx[3] = '{1'b1, 1'b0, 1'b1};
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; bit_in = tx[i];
            tick();
        end
        bit_valid = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        checks++;
        if ({xn, fifo_level} !== {POS, 3'd2}) begin
            errors++;
            $display("FAIL pre_reset: got xn=%h lvl=%0d want %h/2", xn, fifo_level, POS);
        end
        #2;
        nreset = 1'b0;
        #1;
        checks++;
        if ({xn, underrun, fifo_level, bit_ready} !== {32'h0, 1'b0, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got xn=%h u=%b lvl=%0d rdy=%b want 0/0/0/1",
                     xn, underrun, fifo_level, bit_ready);
        end
        @(negedge clock);
        nreset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({underrun, xn} !== {1'b0, 32'h0}) begin
                errors++;
                $display("FAIL post_reset_idle i=%0d: got u=%b xn=%h want 0/0", i, underrun, xn);
            end
        end
        bit_valid = 1'b1; bit_in = 1'b0;
        tick();
        bit_valid = 1'b0;
        checks++;
        if (xn !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_push: got %h want 0", xn);
        end
        for (int i = 0; i < OSR; i++) begin
            tick();
            checks++;
            if (xn !== NEG) begin
                errors++;
                $display("FAIL post_reset_level i=%0d: got %h want %h", i, xn, NEG);
            end
        end
        tick();
        checks++;
        if ({underrun, xn} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL post_reset_underrun: got u=%b xn=%h want 1/0", underrun, xn);
        end
    endtask

    task automatic test_osr1;
        bit tx[$] = '{1'b1, 1'b1, 1'b0};
        bit b, sent;
        logic [32:0] e;
        int cyc = 0;
        enable1 = 1'b1;
        exp_q.push_back({1'b0, 32'h0});
        while (exp_q.size() > 0 && cyc < 50) begin
            sent = 1'b0;
            if (tx.size() > 0) begin
                bit_valid1 = 1'b1; bit_in1 = tx[0]; sent = bit_ready1;
            end else begin
                bit_valid1 = 1'b0;
            end
            tick();
            if (sent) begin
                b = tx.pop_front();
                exp_q.push_back({1'b0, b ? POS : NEG});
                if (tx.size() == 0) exp_q.push_back({1'b1, 32'h0});
            end
            if (xn_valid1) begin
                e = exp_q.pop_front();
                checks++;
                if ({underrun1, xn1} !== e) begin
                    errors++;
                    $display("FAIL osr1 cyc=%0d: got u=%b xn=%h want u=%b xn=%h",
                             cyc, underrun1, xn1, e[32], e[31:0]);
                end
            end
            cyc++;
        end
        bit_valid1 = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL osr1_timeout: got %0d samples left want 0", exp_q.size());
            exp_q.delete();
        end
        tick();
        checks++;
        if ({underrun1, xn1, fifo_level1} !== {1'b0, 32'h0, 3'd0}) begin
            errors++;
            $display("FAIL osr1_idle: got u=%b xn=%h lvl=%0d want 0/0/0", underrun1, xn1, fifo_level1);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_back_to_back();
        test_enable_toggle();
        test_reset_midstream();
        test_osr1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nrz_symbol_mapper.md
Name: nrz_symbol_mapper

Overview:
- Upstream stage of gaussian_fir.
- Accepts a serial bit stream over a valid/ready handshake and buffers it in a small FIFO.
- Maps each bit to a signed NRZ level, 1 -> +AMPL and 0 -> -AMPL.
- Holds each level for OSR consecutive samples, producing the oversampled xn stream that drives the FIR input.

Parameters:
WIDTH, 32, sample width of xn, two's complement; matches the FIR WIDTH.
OSR, 8, samples per symbol; legal range 1..255.
AMPL, 32'h00000100, positive level magnitude (Q8 1.0); -AMPL is its two's complement, truncated to WIDTH.
FIFO_DEPTH, 4, bit FIFO depth; power of two, at least 2.

Ports:
clock  in  1  sample clock, rising edge.
nreset  in  1  asynchronous active-low reset.
bit_in  in  1  data bit.
bit_valid  in  1  bit_in valid.
bit_ready  out  1  FIFO can accept a bit.
enable  in  1  sample strobe; advances the output only when 1.
xn  out  WIDTH  sample to the FIR.
xn_valid  out  1  xn was updated on the last edge.
underrun  out  1  one-cycle pulse: the FIFO was empty at a symbol boundary while active.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is decided: nreset is asynchronous and active-low; the clock is clock.
- Reset values: xn=0, xn_valid=0, underrun=0, fifo_level=0, bit_ready=1, phase=0, state=IDLE, FIFO pointers=0.
- Reset asserted mid-symbol or mid-stream discards all buffered bits; there is no partial-symbol completion.
- bit_ready is combinational: (fifo_level < FIFO_DEPTH). It does not account for a pop in the same cycle.
- Push occurs on an edge where bit_valid && bit_ready.
- Pop condition: enable && phase==0 && fifo_level>0.
- Simultaneous push and pop leave fifo_level unchanged.
- Write and read pointers wrap modulo FIFO_DEPTH.
- Phase counter runs 0..OSR-1 and advances only when enable=1.
  - It wraps to 0 after OSR-1.
  - With OSR=1 the phase is always 0, so every enabled cycle is a symbol boundary.
- State machine (advances only on edges with enable=1):
  - IDLE: phase held at 0.
    - If the FIFO is non-empty: pop, xn <= level(bit), go to ACTIVE; phase becomes 1 (or stays 0 when OSR=1).
    - If the FIFO is empty: xn <= 0, stay in IDLE, no underrun.
  - ACTIVE, phase != 0: xn holds, phase increments.
  - ACTIVE, phase==0:
    - If the FIFO is non-empty: pop and load the new level, stay in ACTIVE.
    - If the FIFO is empty: xn <= 0, underrun pulses high for one cycle, go to IDLE.
- enable=0: state, phase, xn and the FIFO read side all hold; pushes are still accepted; xn_valid <= 0.
- xn_valid <= enable on every edge.
- Latency: a bit pushed at edge T into an empty FIFO, in IDLE with enable held high, appears on xn after edge T+1. It is held for OSR enabled edges.
- level(1) = AMPL[WIDTH-1:0]; level(0) = (~AMPL + 1)[WIDTH-1:0].

Test Plan:
- Defaults (OSR=8, AMPL=0x100), enable=1. Push bits 1,0,1 back-to-back. Required: xn = 0x00000100 for 8 cycles, then 0xFFFFFF00 for 8, then 0x00000100 for 8, then 0; underrun high for exactly one cycle at that boundary; fifo_level returns to 0.
- enable=0, push 5 bits with bit_valid held. Required: the first 4 are accepted, then bit_ready=0 and fifo_level=4; xn_valid=0 and xn=0 throughout.
- Continue from the full FIFO: set enable=1 while bit_valid stays high. Required: a push and a pop on the same edge is not possible on the first pop cycle (bit_ready was 0), so fifo_level drops to 3, the next push makes it 4, and the stream stays continuous with no underrun.
- Toggle enable 1,0,1,0 during a symbol. Required: each level spans exactly 8 enabled cycles; xn_valid mirrors enable delayed by one cycle.
- Assert nreset at phase 3 of a symbol with 2 bits queued. Required: asynchronously xn=0, fifo_level=0, bit_ready=1, underrun=0. After release, xn stays 0 until a new bit is pushed.
- OSR=1 with bits 1,1,0. Required: xn = 0x100, 0x100, 0xFFFFFF00 on consecutive cycles, then 0 with an underrun pulse.
